// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences one Zicsr instruction into read/modify/write cycles on the CSR bus; optional CSR_RO_CHECK_EN rejects writes to read-only CSRs
module csr_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_rs1_data,
    input  logic [4:0]            req_zimm,
    input  logic                  req_rs1_nz,
    input  logic                  req_rd_nz,
    input  logic                  flush,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_illegal,
    output logic                  csr_rd,
    output logic                  csr_wr,
    output logic [ADDR_WIDTH-1:0] csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic [DATA_WIDTH-1:0] csr_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t                state_q;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] src_q, wdata_q, rdata_q, old_val, new_val;
    logic                  rs1_nz_q, rd_nz_q, illegal_q, rd_en, wr_need, ro_hit;
`ifdef CSR_RO_CHECK_EN
    assign ro_hit = addr_q[ADDR_WIDTH-1 -: 2] == 2'b11;
`else
    assign ro_hit = 1'b0;
`endif
    // read skipped only for CSRRW/CSRRWI with rd=x0; write skipped for set/clear with rs1=x0
    always_comb begin
        rd_en   = !(op_q == 2'b01 && !rd_nz_q);
        old_val = rd_en ? csr_rdata : '0;
        new_val = op_q == 2'b01 ? src_q : op_q == 2'b10 ? (old_val | src_q) : (old_val & ~src_q);
        wr_need = op_q == 2'b01 || rs1_nz_q;
    end
    // strobes and response come from registered state; flush kills write and response in the same cycle
    assign req_ready   = state_q == IDLE && !flush;
    assign csr_rd      = state_q == READ && rd_en;
    assign csr_wr      = state_q == WRITE && !flush;
    assign rsp_valid   = state_q == RESP && !flush;
    assign rsp_illegal = rsp_valid && illegal_q;
    assign rsp_rdata   = rdata_q;
    assign csr_addr    = addr_q;
    assign csr_wdata   = wdata_q;
    // access sequencer: latch request, capture old value, issue write, respond
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= 2'b00;
            addr_q    <= '0;
            src_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rs1_nz_q  <= 1'b0;
            rd_nz_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid && req_ready) begin
                    op_q      <= req_funct3[1:0];
                    addr_q    <= req_addr;
                    src_q     <= req_funct3[2] ? {{(DATA_WIDTH-5){1'b0}}, req_zimm} : req_rs1_data;
                    rs1_nz_q  <= req_rs1_nz;
                    rd_nz_q   <= req_rd_nz;
                    illegal_q <= req_funct3[1:0] == 2'b00;
                    rdata_q   <= '0;
                    state_q   <= req_funct3[1:0] == 2'b00 ? RESP : READ;
                end
                READ: begin
                    wdata_q   <= new_val;
                    rdata_q   <= (wr_need && ro_hit) ? '0 : old_val;
                    illegal_q <= wr_need && ro_hit;
                    state_q   <= flush ? IDLE : (wr_need && !ro_hit) ? WRITE : RESP;
                end
                WRITE: state_q <= flush ? IDLE : RESP;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed checks of the CSR access sequencer
module tb_csr_access_ctrl;
    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [2:0]  req_funct3 = 3'b000;
    logic [11:0] req_addr = '0;
    logic [31:0] req_rs1_data = '0;
    logic [4:0]  req_zimm = '0;
    logic        req_rs1_nz = 1'b0, req_rd_nz = 1'b0, flush = 1'b0;
    logic        rsp_valid, rsp_illegal, csr_rd, csr_wr;
    logic [31:0] rsp_rdata, csr_wdata, csr_rdata = '0;
    logic [11:0] csr_addr;
    int          checks = 0, errors = 0;
    logic [4:1]  o_rd, o_wr, o_rv, o_ill, o_ready;
    logic [31:0] o_wdata [1:4];
    logic [31:0] o_rdata [1:4];
    logic [11:0] o_addr1;

    csr_access_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_rs1_data(req_rs1_data),
        .req_zimm(req_zimm), .req_rs1_nz(req_rs1_nz), .req_rd_nz(req_rd_nz), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
        .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata)
    );

    always #5 clk = ~clk;

    // issue one request and record outputs in cycles T+1..T+4; fc selects the cycle carrying flush
    task automatic run(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                       input logic [4:0] z, input logic rnz, input logic dnz, input logic [31:0] old, input int fc);
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_rs1_data = rs1;
        req_zimm = z; req_rs1_nz = rnz; req_rd_nz = dnz; csr_rdata = old;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            flush = (k == fc);
            @(negedge clk);
            o_rd[k] = csr_rd; o_wr[k] = csr_wr; o_rv[k] = rsp_valid; o_ill[k] = rsp_illegal;
            o_ready[k] = req_ready; o_wdata[k] = csr_wdata; o_rdata[k] = rsp_rdata;
            if (k == 1) o_addr1 = csr_addr;
        end
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        if ({csr_rd, csr_wr, rsp_valid, rsp_illegal} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {csr_rd, csr_wr, rsp_valid, rsp_illegal}); end
        checks++;
        if ({rsp_rdata, csr_wdata, csr_addr} !== 76'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {rsp_rdata, csr_wdata, csr_addr}); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_rs_no_write;
        run(3'b010, 12'h301, 32'h0, 5'd0, 1'b0, 1'b1, 32'h4000_0100, 0);
        if (o_rd !== 4'b0001) begin errors++; $display("FAIL rs_rd got %b exp 0001", o_rd); end
        checks++;
        if (o_addr1 !== 12'h301) begin errors++; $display("FAIL rs_addr got %h exp 301", o_addr1); end
        checks++;
        if (o_wr !== 4'b0000) begin errors++; $display("FAIL rs_wr got %b exp 0000", o_wr); end
        checks++;
        if (o_rv !== 4'b0010) begin errors++; $display("FAIL rs_rv got %b exp 0010", o_rv); end
        checks++;
        if (o_rdata[2] !== 32'h4000_0100) begin errors++; $display("FAIL rs_rdata got %h exp 40000100", o_rdata[2]); end
        checks++;
    endtask

    task automatic test_rw;
        run(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1, 32'h1234_5678, 0);
        if (o_rd !== 4'b0001) begin errors++; $display("FAIL rw_rd got %b exp 0001", o_rd); end
        checks++;
        if (o_wr !== 4'b0010) begin errors++; $display("FAIL rw_wr got %b exp 0010", o_wr); end
        checks++;
        if (o_wdata[2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_wdata got %h exp deadbeef", o_wdata[2]); end
        checks++;
        if (o_rv !== 4'b0100 || o_ill !== 4'b0000) begin errors++; $display("FAIL rw_rsp got rv %b ill %b exp 0100 0000", o_rv, o_ill); end
        checks++;
        if (o_rdata[3] !== 32'h1234_5678) begin errors++; $display("FAIL rw_rdata got %h exp 12345678", o_rdata[3]); end
        checks++;
        if (o_ready !== 4'b1000) begin errors++; $display("FAIL rw_ready got %b exp 1000", o_ready); end
        checks++;
    endtask

    task automatic test_imm;
        run(3'b111, 12'h300, 32'hFFFF_FFFF, 5'h05, 1'b1, 1'b1, 32'h0000_00FF, 0);
        if (o_wr !== 4'b0010 || o_wdata[2] !== 32'h0000_00FA) begin errors++; $display("FAIL rci_wdata got wr %b %h exp 0010 000000fa", o_wr, o_wdata[2]); end
        checks++;
        if (o_rv !== 4'b0100 || o_rdata[3] !== 32'h0000_00FF) begin errors++; $display("FAIL rci_rsp got %b %h exp 0100 000000ff", o_rv, o_rdata[3]); end
        checks++;
        run(3'b110, 12'h300, 32'hFFFF_FFFF, 5'h00, 1'b0, 1'b1, 32'h0000_0055, 0);
        if (o_wr !== 4'b0000 || o_rv !== 4'b0010) begin errors++; $display("FAIL rsi0 got wr %b rv %b exp 0000 0010", o_wr, o_rv); end
        checks++;
        if (o_rdata[2] !== 32'h0000_0055) begin errors++; $display("FAIL rsi0_rdata got %h exp 00000055", o_rdata[2]); end
        checks++;
        run(3'b001, 12'h305, 32'h0000_0001, 5'd0, 1'b1, 1'b0, 32'h0000_0077, 0);
        if (o_rd !== 4'b0000 || o_wr !== 4'b0010) begin errors++; $display("FAIL rw_x0 got rd %b wr %b exp 0000 0010", o_rd, o_wr); end
        checks++;
        if (o_rdata[3] !== 32'h0 || o_wdata[2] !== 32'h1) begin errors++; $display("FAIL rw_x0_data got %h %h exp 0 1", o_rdata[3], o_wdata[2]); end
        checks++;
    endtask

    task automatic test_flush;
        run(3'b001, 12'h340, 32'hCAFE_0000, 5'd0, 1'b1, 1'b1, 32'h1, 2);
        if (o_wr !== 4'b0000 || o_rv !== 4'b0000) begin errors++; $display("FAIL flush_wr got wr %b rv %b exp 0000 0000", o_wr, o_rv); end
        checks++;
        if (o_ready[3] !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", o_ready[3]); end
        checks++;
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'b001; req_rd_nz = 1'b1; #1;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL idle_flush_ready got %b exp 0", req_ready); end
        checks++;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        if (csr_rd !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL idle_flush_accept got rd %b ready %b exp 0 1", csr_rd, req_ready); end
        checks++;
    endtask

    task automatic test_illegal;
        run(3'b100, 12'h300, 32'h0, 5'd0, 1'b1, 1'b1, 32'h1, 0);
        if (o_rv !== 4'b0001 || o_ill !== 4'b0001) begin errors++; $display("FAIL bad_f3 got rv %b ill %b exp 0001 0001", o_rv, o_ill); end
        checks++;
        if (o_rd !== 4'b0000 || o_wr !== 4'b0000 || o_rdata[1] !== 32'h0) begin errors++; $display("FAIL bad_f3_strobes got rd %b wr %b %h exp 0 0 0", o_rd, o_wr, o_rdata[1]); end
        checks++;
        run(3'b001, 12'hF11, 32'h0000_00AA, 5'd0, 1'b1, 1'b1, 32'h0000_0099, 0);
`ifdef CSR_RO_CHECK_EN
        if (o_rd !== 4'b0001 || o_wr !== 4'b0000) begin errors++; $display("FAIL ro_strobes got rd %b wr %b exp 0001 0000", o_rd, o_wr); end
        checks++;
        if (o_rv !== 4'b0010 || o_ill !== 4'b0010 || o_rdata[2] !== 32'h0) begin errors++; $display("FAIL ro_rsp got %b %b %h exp 0010 0010 0", o_rv, o_ill, o_rdata[2]); end
        checks++;
`else
        if (o_rd !== 4'b0001 || o_wr !== 4'b0010) begin errors++; $display("FAIL ro_strobes got rd %b wr %b exp 0001 0010", o_rd, o_wr); end
        checks++;
        if (o_rv !== 4'b0100 || o_ill !== 4'b0000 || o_rdata[3] !== 32'h99) begin errors++; $display("FAIL ro_rsp got %b %b %h exp 0100 0000 99", o_rv, o_ill, o_rdata[3]); end
        checks++;
`endif
    endtask

    task automatic test_async_reset;
        logic stray;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h341; req_rs1_data = 32'h5;
        req_rs1_nz = 1'b1; req_rd_nz = 1'b1; csr_rdata = 32'h3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (csr_rd !== 1'b1) begin errors++; $display("FAIL arst_pre_rd got %b exp 1", csr_rd); end
        checks++;
        #2 rst = 1'b0; #1;
        if ({csr_rd, csr_wr, rsp_valid, csr_addr, csr_wdata} !== 47'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL arst_outputs got %b %b %b %h %h ready %b exp all 0 ready 1", csr_rd, csr_wr, rsp_valid, csr_addr, csr_wdata, req_ready); end
        checks++;
        @(negedge clk); rst = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            stray |= csr_rd | csr_wr | rsp_valid;
        end
        if (stray !== 1'b0) begin errors++; $display("FAIL arst_stray got %b exp 0", stray); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_rs_no_write();
        test_rw();
        test_imm();
        test_flush();
        test_illegal();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
